// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt requester.
// FSM encoding, id-width helper and default timing constants.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } irq_state_e;

  localparam int HOLDOFF_DEF = 8;
  localparam int TIMEOUT_DEF = 64;

  function automatic int IRQ_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// irq_edge_latch: one request line's rising-edge detector and pending bit.
// A new edge in the same cycle as a clear keeps the bit set.
import irq_pkg::*;

module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic clr_i,
  output logic pending_o
);

  logic src_q;
  logic pend_q;
  logic pend_d;
  logic rise;

  assign rise   = src_i & ~src_q;
  // Set has priority over clear so a fresh edge is never lost on ack
  assign pend_d = rise | (pend_q & ~clr_i);

  // Sample the line and hold the pending flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/irq_requester.sv
// irq_requester: fixed-priority interrupt initiator with ack hold-off.
// Optional request abandonment when IRQ_TIMEOUT_EN is defined.
module irq_requester
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int HOLDOFF = HOLDOFF_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            irq_src,
  input  logic [NUM_SRC-1:0]            irq_mask,
  input  logic                          ack,
  output logic                          int_flag,
  output logic [IRQ_ID_W(NUM_SRC)-1:0]  irq_id,
  output logic [NUM_SRC-1:0]            pending,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IW = IRQ_ID_W(NUM_SRC);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  irq_state_e   state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] clr;
  logic [IW-1:0] win;
  logic          clr_en;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_latch u_latch (
      .clk      (clk),
      .reset    (reset),
      .src_i    (irq_src[g]),
      .clr_i    (clr[g]),
      .pending_o(pending[g])
    );
  end

  assign cand = pending & ~irq_mask;

  // Lowest unmasked pending index wins
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win = IW'(i);
    end
  end

  // One-hot clear of the source being serviced
  always_comb begin
    clr = '0;
    if (clr_en) clr[id_q] = 1'b1;
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          terr_q, terr_d;
`endif

  // Next-state logic: request, wait for ack, then enforce the gap
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    hcnt_d  = hcnt_q;
    clr_en  = 1'b0;
`ifdef IRQ_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    terr_d  = terr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          id_d    = win;
          state_d = REQ;
`ifdef IRQ_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      REQ: begin
        if (ack) begin
          clr_en  = 1'b1;
          hcnt_d  = HW'(HOLDOFF - 1);
          state_d = HOLD;
        end
`ifdef IRQ_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          clr_en  = 1'b1;
          terr_d  = 1'b1;
          hcnt_d  = HW'(HOLDOFF - 1);
          state_d = HOLD;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (hcnt_q == '0) state_d = IDLE;
        else hcnt_d = hcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, id and hold-off registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      hcnt_q  <= hcnt_d;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  // Ack-wait counter and sticky abandonment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign int_flag = (state_q == REQ);
  assign busy     = (state_q != IDLE);
  assign irq_id   = id_q;

endmodule

// File: tb/tb_irq_requester.sv
// tb_irq_requester: directed plus random checks against a cycle-stamp model.
// Honours IRQ_TIMEOUT_EN the same way the design does.
module tb_irq_requester;

  localparam int N  = 4;
  localparam int HO = 8;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic [N-1:0] irq_mask;
  logic         ack;
  logic         int_flag;
  logic [1:0]   irq_id;
  logic [N-1:0] pending;
  logic         busy;
  logic         timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // model: pending set, request flag, request start stamp, hold-off end stamp
  int           cyc = 0;
  logic [N-1:0] m_prev, m_pend;
  bit           m_req, m_terr;
  int           m_id, m_start, m_next_ok;

  irq_requester #(.NUM_SRC(N), .HOLDOFF(HO), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .irq_mask   (irq_mask),
    .ack        (ack),
    .int_flag   (int_flag),
    .irq_id     (irq_id),
    .pending    (pending),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_req = 0; m_terr = 0;
    m_id = 0; m_start = 0; m_next_ok = cyc;
  endtask

  task automatic model_edge();
    logic [N-1:0] rises, clr, cand;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    rises = irq_src & ~m_prev;
    clr   = '0;
    if (m_req) begin
      if (ack) begin
        clr[m_id] = 1'b1; m_req = 0; m_next_ok = cyc + HO;
      end
`ifdef IRQ_TIMEOUT_EN
      else if (cyc - m_start == TO) begin
        clr[m_id] = 1'b1; m_req = 0; m_terr = 1; m_next_ok = cyc + HO;
      end
`endif
    end else if (cyc > m_next_ok) begin
      cand = m_pend & ~irq_mask;
      if (cand != '0) begin
        m_req = 1; m_id = lowest(cand); m_start = cyc;
      end
    end
    m_pend = (m_pend & ~clr) | rises;
    m_prev = irq_src;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("int_flag", 32'(int_flag), 32'(m_req));
    chk("irq_id", 32'(irq_id), 32'(m_id));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("busy", 32'(busy), 32'(m_req || (cyc < m_next_ok)));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int n;

  initial begin
    reset = 1'b1; irq_src = '0; irq_mask = '0; ack = 1'b0;
    model_reset();
    step(); step();
    reset = 1'b0;
    step();

    // single edge on source 2, then ack
    irq_src = 4'b0100; step();
    chk("s1_pend", 32'(pending), 32'h4);
    step();
    chk("s1_flag", 32'(int_flag), 32'h1);
    chk("s1_id", 32'(irq_id), 32'h2);
    step(); step();
    ack = 1'b1; step(); ack = 1'b0; irq_src = '0;
    chk("s1_clr", 32'(pending), 32'h0);
    repeat (HO + 2) step();

    // simultaneous edges 1 and 3: priority and hold-off spacing
    irq_src = 4'b1010; step(); step();
    chk("s2_id1", 32'(irq_id), 32'h1);
    step();
    ack = 1'b1; step(); ack = 1'b0; irq_src = '0;
    n = 0;
    for (int i = 1; i <= 3 * HO; i++) begin
      step();
      if (int_flag) begin n = i; break; end
    end
    chk("s2_gap", 32'(n), 32'(HO + 1));
    chk("s2_id3", 32'(irq_id), 32'h3);
    ack = 1'b1; step(); ack = 1'b0;
    repeat (HO + 2) step();

    // masked source latches but does not request
    irq_mask = 4'b0001; irq_src = 4'b0001;
    repeat (4) step();
    chk("s3_masked", 32'(int_flag), 32'h0);
    irq_mask = '0; step(); step();
    chk("s3_unmask", 32'(int_flag), 32'h1);
    ack = 1'b1; step(); ack = 1'b0; irq_src = '0;
    repeat (HO + 2) step();

    // new edge on the serviced source during its ack
    irq_src = 4'b0100; step(); step(); step();
    irq_src = 4'b0000; step();
    irq_src = 4'b0100; ack = 1'b1; step(); ack = 1'b0;
    chk("s4_keep", 32'(pending[2]), 32'h1);
    repeat (HO + 1) step();
    chk("s4_rereq", 32'(int_flag), 32'h1);
    ack = 1'b1; step(); ack = 1'b0; irq_src = '0;
    repeat (HO + 2) step();

    // asynchronous reset in the middle of a request
    irq_src = 4'b0001; step(); step();
    chk("s5_req", 32'(int_flag), 32'h1);
    reset = 1'b1; #1;
    model_reset();
    check_all();
    chk("s5_rst", 32'({int_flag, busy, pending}), 32'h0);
    ack = 1'b1; step();
    reset = 1'b0; step(); ack = 1'b0;
    chk("s5_ackign", 32'(busy), 32'h0);
    irq_src = '0;
    repeat (HO + 4) step();

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) irq_src[b] = ~irq_src[b];
      if ($urandom_range(31) == 0) irq_mask = N'($urandom);
      ack   = ($urandom_range(3) == 0);
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b0; ack = 1'b0; irq_mask = '0; irq_src = '0;
    repeat (HO + 4) step();

    // no ack for a long time
    irq_src = 4'b0001;
    repeat (1000) step();
`ifdef IRQ_TIMEOUT_EN
    chk("noack_err", 32'(timeout_err), 32'h1);
`else
    chk("noack_hold", 32'(int_flag), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_requester.md
# irq_requester

Interrupt initiator sitting outside the processor core. It collects rising-edge requests from up to NUM_SRC synchronous peripheral lines, arbitrates by fixed priority, and drives the core's `int_flag` input. It holds `int_flag` until the core's interrupt control unit returns `ack`, then enforces a hold-off gap before it issues the next request.

## Interface
- NUM_SRC, 4, number of request lines (2..16)
- HOLDOFF, 8, minimum cycles between `ack` and the next `int_flag` (must be ≥1)
- TIMEOUT, 64, cycles to wait for `ack` before abandoning a request (used only with the macro)
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- irq_src  in  NUM_SRC  peripheral request lines, synchronous to `clk`; a rising edge is a request
- irq_mask  in  NUM_SRC  1 = source is latched but not selected
- ack  in  1  core acknowledge; a pulse of at least one cycle, sampled only in REQ
- int_flag  out  1  interrupt request to the core
- irq_id  out  clog2(NUM_SRC)  index of the source being requested; stable while `int_flag`=1
- pending  out  NUM_SRC  latched, not-yet-serviced requests
- busy  out  1  1 in REQ or HOLD
- timeout_err  out  1  sticky; set when a request is abandoned

## Operation
- Edge detect: `irq_src_q` is registered every cycle; `edge = irq_src & ~irq_src_q`; `pending |= edge`.
- Coalescing: an edge on a source whose pending bit is already set is lost (no counting).
- Selection: `cand = pending & ~irq_mask`; the lowest set index wins.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if `cand != 0`, register `irq_id` = winner, set `int_flag`=1, go to REQ. Otherwise stay.
  - REQ: on `ack`=1, clear `pending[irq_id]`, set `int_flag`=0, load the hold-off counter with HOLDOFF-1, go to HOLD.
  - HOLD: decrement; at 0 go to IDLE. `ack` is ignored.
- Set beats clear: if a new edge on `irq_id` arrives in the same cycle as `ack`, the pending bit stays 1.
- Masking a source while it is in REQ does not withdraw the request.
- `ack` received in IDLE or HOLD is ignored and has no side effects.
- Reset at any point, including mid-REQ: the FSM goes to IDLE and every register goes to 0 immediately (asynchronous reset).

## Timing
- Reset values: `int_flag`=0, `irq_id`=0, `pending`=0, `busy`=0, `timeout_err`=0, `irq_src_q`=0.
- An `irq_src` rise sampled at edge n sets `pending` at n+1. `int_flag` goes to 1 at n+2 if the FSM is in IDLE and the source is unmasked.
- `ack` sampled high at edge m gives `int_flag`=0 and the pending bit cleared at m+1.
- The earliest next `int_flag`=1 is at m+1+HOLDOFF+1.
- A source that is held high produces only one request. It must fall and rise again before it can request again.

## Configuration
- IRQ_TIMEOUT_EN defined:
  - A counter runs in REQ. If TIMEOUT cycles pass without `ack`, `int_flag` drops, `pending[irq_id]` is cleared, `timeout_err` is set, and the FSM goes to HOLD.
  - `timeout_err` is cleared only by reset.
  - If `ack` and expiry happen in the same cycle, `ack` wins.
- IRQ_TIMEOUT_EN undefined: REQ waits for `ack` indefinitely; `timeout_err` is tied to 0 and there is no counter logic.

## Structure
- Shared package `irq_pkg` holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2)
  - the `IRQ_ID_W` width function
  - default constants HOLDOFF_DEF and TIMEOUT_DEF
- One sub-module, `irq_edge_latch`, holds the per-source edge detector, the pending bit, and the set-beats-clear rule. The top level instantiates it NUM_SRC times.
- The priority encoder, FSM and counters live in the top level.

## Test plan
- Reset then a single edge on `irq_src[2]` at cycle 5 → `pending`=4'b0100 at cycle 6, `int_flag`=1 and `irq_id`=2 at cycle 7. `ack` at cycle 10 → `int_flag`=0 and `pending`=0 at cycle 11.
- Simultaneous edges on sources 1 and 3 → `irq_id`=1 first. After `ack`, the next `int_flag` goes high exactly HOLDOFF+1 cycles later with `irq_id`=3.
- `irq_mask`=4'b0001 with an edge on source 0 → `pending[0]`=1 and `int_flag` stays 0. Clearing the mask → `int_flag`=1 two cycles later.
- New edge on source 2 in the same cycle as `ack` for source 2 → `pending[2]` stays 1, and it is re-requested after the hold-off.
- Assert `reset` mid-REQ → all outputs are 0 within the same cycle, and a later `ack` is ignored.
- With IRQ_TIMEOUT_EN and no `ack` → `int_flag` drops TIMEOUT cycles after rising and `timeout_err`=1 stays set. Without the macro, `int_flag` stays high for 1000 cycles.
